branch_predictor_bht: RTL and testbench

//  Parametrised successor to the single-counter predictor. Holds a table of N-bit saturating counters

---
 rtl/bp_pkg.sv | 39 +++
 rtl/bp_inflight_fifo.sv | 55 +++++
 rtl/branch_predictor_bht.sv | 141 ++++++++++++++
 tb/tb_branch_predictor_bht.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared types and helpers for the BHT branch predictor.
// Build option: BP_GSHARE_EN adds the global-history field to queue entries.
package bp_pkg;

    localparam int BP_INDEX_BITS = 6;
    localparam int BP_CTR_BITS   = 2;
    localparam int BP_GHR_BITS   = 6;

    // Saturation limits of the default counter width
    localparam logic [BP_CTR_BITS-1:0] BP_CTR_MIN = '0;
    localparam logic [BP_CTR_BITS-1:0] BP_CTR_MAX = '1;

    // In-flight record at the default geometry; the top re-declares this
    // layout at its own parameter widths.
    typedef struct packed {
        logic [BP_INDEX_BITS-1:0] idx;
        logic                     pred;
`ifdef BP_GSHARE_EN
        logic [BP_GHR_BITS-1:0]   ghr;
`endif
    } bp_entry_t;

    // Word-aligned PC folded with history; caller truncates to its index width.
    function automatic logic [31:0] bp_index(input logic [31:0] pc, input logic [31:0] ghr);
        return (pc >> 2) ^ ghr;
    endfunction

    // One saturating step of a ctr_bits-wide counter.
    function automatic logic [31:0] bp_sat_step(input logic [31:0] ctr, input logic taken,
                                                input int ctr_bits);
        logic [31:0] max_v;
        max_v = (32'd1 << ctr_bits) - 32'd1;
        if (taken)
            return (ctr == max_v) ? ctr : ctr + 32'd1;
        else
            return (ctr == 32'd0) ? ctr : ctr - 32'd1;
    endfunction

endpackage

// File: rtl/bp_inflight_fifo.sv
// In-order queue linking decode-time predictions to their resolutions.
// Pointers wrap modulo DEPTH (power of two); clear empties it in one cycle.
module bp_inflight_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             clear_i,
    input  logic [WIDTH-1:0] wr_data_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [PW:0]      count_q;
    logic             do_push, do_pop;

    // Status flags and guarded push/pop strobes
    always_comb begin
        full_o    = (count_q == (PW+1)'(DEPTH));
        empty_o   = (count_q == '0);
        do_push   = push_i & ~full_o & ~clear_i;
        do_pop    = pop_i & ~empty_o;
        rd_data_o = mem_q[rd_ptr_q];
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end

    // Entry storage; contents are don't-care until pushed
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/branch_predictor_bht.sv
// Table of saturating counters with an in-flight queue of pending predictions.
// Build option: BP_GSHARE_EN XORs speculative global history into the index.
module branch_predictor_bht
    import bp_pkg::*;
#(
    parameter int INDEX_BITS = BP_INDEX_BITS,
    parameter int CTR_BITS   = BP_CTR_BITS,
    parameter int INIT_CTR   = 1,
    parameter int QDEPTH     = 4,
    parameter int GHR_BITS   = BP_GHR_BITS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lookup_valid,
    input  logic [31:0] lookup_pc,
    input  logic [31:0] lookup_offset,
    output logic        lookup_ready,
    output logic [31:0] branch_addr,
    output logic        prediction,
    output logic        pred_valid,
    input  logic        update_valid,
    input  logic        actual_branch_decision,
    output logic        mispredict,
    input  logic        flush
);
    localparam int TBL_DEPTH = 2**INDEX_BITS;

    if (GHR_BITS > INDEX_BITS) begin : g_bad_ghr
        $error("GHR_BITS must not exceed INDEX_BITS");
    end

    typedef struct packed {
        logic [INDEX_BITS-1:0] idx;
        logic                  pred;
`ifdef BP_GSHARE_EN
        logic [GHR_BITS-1:0]   ghr;
`endif
    } entry_t;

    logic [CTR_BITS-1:0]   ctr_q [TBL_DEPTH];
    logic [CTR_BITS-1:0]   ctr_next;
    logic [INDEX_BITS-1:0] lk_idx;
    logic                  lk_pred, accept, do_pop, q_full, q_empty;
    entry_t                push_entry, head;
    logic [31:0]           branch_addr_q;
    logic                  prediction_q, pred_valid_q, mispredict_q;

`ifdef BP_GSHARE_EN
    logic [GHR_BITS-1:0] spec_ghr_q, spec_ghr_d, arch_ghr_q, arch_ghr_d;
    logic [GHR_BITS-1:0] unused_head_ghr;
    assign unused_head_ghr = head.ghr;
`endif

    // Lookup acceptance, table read (pre-update value) and queue entry build
    always_comb begin
        accept = lookup_valid & ~q_full & ~flush;
        do_pop = update_valid & ~q_empty;
`ifdef BP_GSHARE_EN
        lk_idx = INDEX_BITS'(bp_index(lookup_pc, 32'(spec_ghr_q)));
`else
        lk_idx = INDEX_BITS'(bp_index(lookup_pc, 32'd0));
`endif
        lk_pred         = ctr_q[lk_idx][CTR_BITS-1];
        push_entry      = '0;
        push_entry.idx  = lk_idx;
        push_entry.pred = lk_pred;
`ifdef BP_GSHARE_EN
        push_entry.ghr  = spec_ghr_q;
`endif
        ctr_next = CTR_BITS'(bp_sat_step(32'(ctr_q[head.idx]), actual_branch_decision, CTR_BITS));
    end

    bp_inflight_fifo #(
        .DEPTH (QDEPTH),
        .WIDTH ($bits(entry_t))
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push_i    (accept),
        .pop_i     (do_pop),
        .clear_i   (flush),
        .wr_data_i (push_entry),
        .rd_data_o (head),
        .full_o    (q_full),
        .empty_o   (q_empty)
    );

    // Counter table: reset to INIT_CTR, trained only by the popped head entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < TBL_DEPTH; i++) ctr_q[i] <= CTR_BITS'(INIT_CTR);
        end else if (do_pop) begin
            ctr_q[head.idx] <= ctr_next;
        end
    end

    // Registered prediction, target and mispredict pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branch_addr_q <= '0;
            prediction_q  <= 1'b0;
            pred_valid_q  <= 1'b0;
            mispredict_q  <= 1'b0;
        end else begin
            branch_addr_q <= lookup_pc + lookup_offset;
            prediction_q  <= accept & lk_pred;
            pred_valid_q  <= accept;
            mispredict_q  <= do_pop & (head.pred != actual_branch_decision);
        end
    end

`ifdef BP_GSHARE_EN
    // History next-state: architectural follows outcomes, speculative follows
    // predictions and is repaired from architectural on flush
    always_comb begin
        arch_ghr_d = arch_ghr_q;
        spec_ghr_d = spec_ghr_q;
        if (do_pop) arch_ghr_d = (arch_ghr_q << 1) | GHR_BITS'(actual_branch_decision);
        if (flush)       spec_ghr_d = arch_ghr_d;
        else if (accept) spec_ghr_d = (spec_ghr_q << 1) | GHR_BITS'(lk_pred);
    end

    // History registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            arch_ghr_q <= '0;
            spec_ghr_q <= '0;
        end else begin
            arch_ghr_q <= arch_ghr_d;
            spec_ghr_q <= spec_ghr_d;
        end
    end
`endif

    assign lookup_ready = ~q_full;
    assign branch_addr  = branch_addr_q;
    assign prediction   = prediction_q;
    assign pred_valid   = pred_valid_q;
    assign mispredict   = mispredict_q;

endmodule

// File: tb/tb_branch_predictor_bht.sv
module tb_branch_predictor_bht;

    logic        clk = 1'b0;
    logic        rst;
    logic        lookup_valid, update_valid, actual_branch_decision, flush;
    logic [31:0] lookup_pc, lookup_offset;
    logic        lookup_ready, prediction, pred_valid, mispredict;
    logic [31:0] branch_addr;

    always #5 clk = ~clk;

    branch_predictor_bht dut (
        .clk                    (clk),
        .rst                    (rst),
        .lookup_valid           (lookup_valid),
        .lookup_pc              (lookup_pc),
        .lookup_offset          (lookup_offset),
        .lookup_ready           (lookup_ready),
        .branch_addr            (branch_addr),
        .prediction             (prediction),
        .pred_valid             (pred_valid),
        .update_valid           (update_valid),
        .actual_branch_decision (actual_branch_decision),
        .mispredict             (mispredict),
        .flush                  (flush)
    );

    int total = 0;
    int bad   = 0;

    // Reference: 64 counters in 0..3 plus an ordered list of pending predictions
    typedef struct {int idx; bit pred;} pend_t;
    int    mdl_ctr [64];
    pend_t mdl_q[$];

    typedef struct {
        bit lv; logic [31:0] pc; logic [31:0] off; bit uv; bit act; bit fl;
        bit pv; bit pred; bit mis; logic [31:0] addr;
    } vec_t;
    vec_t vq[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic idle_inputs();
        lookup_valid = 0; update_valid = 0; actual_branch_decision = 0; flush = 0;
        lookup_pc = 0; lookup_offset = 0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst = 1'b1;
        foreach (mdl_ctr[i]) mdl_ctr[i] = 1;
        mdl_q.delete();
        #2;
        chk("rst_pred_valid", pred_valid, 0);
        chk("rst_prediction", prediction, 0);
        chk("rst_branch_addr", branch_addr, 0);
        chk("rst_mispredict", mispredict, 0);
        chk("rst_ready", lookup_ready, 1);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One clock: predict with the model, drive, then compare registered outputs
    task automatic cycle(input bit lv, input logic [31:0] pc, input logic [31:0] off,
                         input bit uv, input bit act, input bit fl);
        int idx; bit full, accept, e_pred, e_mis; logic [31:0] e_addr; pend_t h;
        full = (mdl_q.size() == 4);
        chk("lookup_ready", lookup_ready, !full);
        accept = lv && !full && !fl;
        idx    = int'(pc >> 2) % 64;
        e_pred = accept && (mdl_ctr[idx] >= 2);
        e_addr = pc + off;
        e_mis  = 0;
        if (uv && mdl_q.size() > 0) begin
            h = mdl_q.pop_front();
            e_mis = (h.pred != act);
            if (act) mdl_ctr[h.idx] = (mdl_ctr[h.idx] < 3) ? mdl_ctr[h.idx] + 1 : 3;
            else     mdl_ctr[h.idx] = (mdl_ctr[h.idx] > 0) ? mdl_ctr[h.idx] - 1 : 0;
        end
        if (accept) mdl_q.push_back('{idx, e_pred});
        if (fl) mdl_q.delete();
        lookup_valid = lv; lookup_pc = pc; lookup_offset = off;
        update_valid = uv; actual_branch_decision = act; flush = fl;
        @(posedge clk);
        #1;
        chk("pred_valid", pred_valid, accept);
        chk("prediction", prediction, e_pred);
        chk("branch_addr", branch_addr, e_addr);
        chk("mispredict", mispredict, e_mis);
        idle_inputs();
    endtask

    task automatic add(input bit lv, input logic [31:0] pc, input logic [31:0] off,
                       input bit uv, input bit act, input bit fl,
                       input bit pv, input bit pred, input bit mis, input logic [31:0] addr);
        vq.push_back('{lv, pc, off, uv, act, fl, pv, pred, mis, addr});
    endtask

    initial begin
        // lookup / update sequence at pc=0x100 (index 0), counter starts at 1
        add(1, 32'h100, 32'h20, 0, 0, 0,  1, 0, 0, 32'h120);
        add(0, 32'hFFFF_FFF0, 32'h20, 1, 1, 0,  0, 0, 1, 32'h10);   // ctr 2
        add(1, 32'h100, 32'h4, 0, 0, 0,  1, 1, 0, 32'h104);
        add(0, 32'h0, 32'h0, 1, 1, 0,  0, 0, 0, 32'h0);              // ctr 3
        add(1, 32'h100, 32'h4, 0, 0, 0,  1, 1, 0, 32'h104);
        add(0, 32'h0, 32'h0, 1, 1, 0,  0, 0, 0, 32'h0);              // stays 3
        add(1, 32'h100, 32'h4, 0, 0, 0,  1, 1, 0, 32'h104);
        add(0, 32'h0, 32'h0, 1, 1, 0,  0, 0, 0, 32'h0);              // stays 3
        add(1, 32'h100, 32'h4, 0, 0, 0,  1, 1, 0, 32'h104);
        add(0, 32'h0, 32'h0, 1, 0, 0,  0, 0, 1, 32'h0);              // ctr 2
        add(1, 32'h100, 32'h4, 0, 0, 0,  1, 1, 0, 32'h104);
        add(0, 32'h0, 32'h0, 1, 0, 0,  0, 0, 1, 32'h0);              // ctr 1
        add(1, 32'h100, 32'h4, 0, 0, 0,  1, 0, 0, 32'h104);
        add(0, 32'h0, 32'h0, 1, 0, 0,  0, 0, 0, 32'h0);              // ctr 0
        add(1, 32'h100, 32'h4, 0, 0, 0,  1, 0, 0, 32'h104);
        add(0, 32'h0, 32'h0, 1, 0, 0,  0, 0, 0, 32'h0);              // stays 0
        add(1, 32'h100, 32'h4, 0, 0, 0,  1, 0, 0, 32'h104);
        add(0, 32'h0, 32'h0, 1, 1, 0,  0, 0, 1, 32'h0);              // ctr 1
        add(0, 32'h0, 32'h0, 1, 1, 0,  0, 0, 0, 32'h0);              // empty: ignored
        add(1, 32'h100, 32'h4, 0, 0, 0,  1, 0, 0, 32'h104);          // still 1
        add(0, 32'h0, 32'h0, 1, 0, 0,  0, 0, 0, 32'h0);              // ctr 0
        add(1, 32'h100, 32'h4, 0, 0, 0,  1, 0, 0, 32'h104);
        add(0, 32'h0, 32'h0, 1, 1, 0,  0, 0, 1, 32'h0);              // ctr 1
        add(1, 32'h100, 32'h4, 0, 0, 0,  1, 0, 0, 32'h104);
        add(1, 32'h100, 32'h4, 1, 1, 0,  1, 0, 1, 32'h104);          // read-before-write, ctr 2
        add(0, 32'h0, 32'h0, 1, 1, 0,  0, 0, 1, 32'h0);              // ctr 3
        add(1, 32'h100, 32'h4, 0, 0, 0,  1, 1, 0, 32'h104);
        add(0, 32'h0, 32'h0, 1, 1, 0,  0, 0, 0, 32'h0);
        add(1, 32'h100, 32'h4, 0, 0, 1,  0, 0, 0, 32'h104);          // flush rejects lookup
        add(1, 32'h100, 32'h4, 0, 0, 0,  1, 1, 0, 32'h104);          // counter kept
        add(0, 32'h0, 32'h0, 1, 1, 0,  0, 0, 0, 32'h0);

        apply_reset();
        foreach (vq[i]) begin
            cycle(vq[i].lv, vq[i].pc, vq[i].off, vq[i].uv, vq[i].act, vq[i].fl);
            chk($sformatf("tbl%0d_pv", i), pred_valid, vq[i].pv);
            chk($sformatf("tbl%0d_pred", i), prediction, vq[i].pred);
            chk($sformatf("tbl%0d_mis", i), mispredict, vq[i].mis);
            chk($sformatf("tbl%0d_addr", i), branch_addr, vq[i].addr);
        end

        // queue full: ready drops, extra lookup rejected, one pop reopens it
        apply_reset();
        for (int i = 0; i < 4; i++) cycle(1, 32'h400 + 32'(4*i), 32'h8, 0, 0, 0);
        chk("full_ready_low", lookup_ready, 0);
        cycle(1, 32'h500, 32'h8, 0, 0, 0);
        chk("full_reject_pv", pred_valid, 0);
        cycle(1, 32'h500, 32'h8, 1, 0, 0);
        chk("full_upd_reject_pv", pred_valid, 0);
        chk("ready_after_pop", lookup_ready, 1);

        // flush with an update at the head and two younger entries
        apply_reset();
        cycle(1, 32'h204, 32'h0, 0, 0, 0);
        cycle(1, 32'h300, 32'h0, 0, 0, 0);
        cycle(1, 32'h304, 32'h0, 0, 0, 0);
        cycle(1, 32'h204, 32'h0, 1, 1, 1);
        chk("flush_mispredict", mispredict, 1);
        chk("flush_lookup_rejected", pred_valid, 0);
        chk("flush_ready", lookup_ready, 1);
        cycle(0, 32'h0, 32'h0, 1, 0, 0);
        chk("flush_queue_empty", mispredict, 0);
        cycle(1, 32'h204, 32'h0, 0, 0, 0);
        chk("flush_ctr_incremented", prediction, 1);

        // reset in the middle of traffic loses in-flight entries and trained counters
        apply_reset();
        cycle(1, 32'h100, 32'h0, 0, 0, 0);
        cycle(0, 32'h0, 32'h0, 1, 1, 0);
        cycle(1, 32'h100, 32'h0, 0, 0, 0);
        chk("pre_reset_pred", prediction, 1);
        #2;
        apply_reset();
        cycle(0, 32'h0, 32'h0, 1, 1, 0);
        chk("post_reset_empty", mispredict, 0);
        cycle(1, 32'h100, 32'h0, 0, 0, 0);
        chk("post_reset_ctr", prediction, 0);

        // randomized traffic over a handful of table entries
        apply_reset();
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] pc;
            pc = ($urandom & 32'hFFFF_FF00) | 32'($urandom_range(0, 3) << 2);
            if ($urandom_range(0, 299) == 0) apply_reset();
            cycle($urandom_range(0, 2) != 0, pc, $urandom, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 19) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
